// File: rtl/switch_nxn_core.sv
// N-port packet switch: per-output round-robin arbitration into a FIFO,
// pull-style read port per output, and a saturating illegal-address drop counter.
module switch_nxn_core #(
    parameter int NUM_PORTS  = 4,
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_PORTS*ADDR_W-1:0]   addr_in,
    input  logic [NUM_PORTS*DATA_W-1:0]   data_in,
    input  logic [NUM_PORTS-1:0]          valid_in,
    output logic [NUM_PORTS-1:0]          in_ack,
    input  logic [NUM_PORTS-1:0]          data_rd,
    output logic [NUM_PORTS*ADDR_W-1:0]   addr_out,
    output logic [NUM_PORTS*DATA_W-1:0]   data_out,
    output logic [NUM_PORTS-1:0]          valid_out,
    output logic [NUM_PORTS-1:0]          rcv_rdy,
    output logic [15:0]                   drop_cnt
);
    localparam int DEST_W = $clog2(NUM_PORTS);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int ENT_W  = ADDR_W + DATA_W;

    logic [ENT_W-1:0]            mem_q [NUM_PORTS][FIFO_DEPTH];
    logic [ENT_W-1:0]            mem_d [NUM_PORTS][FIFO_DEPTH];
    logic [PTR_W-1:0]            wr_q [NUM_PORTS], wr_d [NUM_PORTS];
    logic [PTR_W-1:0]            rd_q [NUM_PORTS], rd_d [NUM_PORTS];
    logic [CNT_W-1:0]            cnt_q [NUM_PORTS], cnt_d [NUM_PORTS];
    logic [DEST_W-1:0]           rr_q [NUM_PORTS], rr_d [NUM_PORTS];
    logic [NUM_PORTS*ADDR_W-1:0] addr_out_q, addr_out_d;
    logic [NUM_PORTS*DATA_W-1:0] data_out_q, data_out_d;
    logic [NUM_PORTS-1:0]        valid_out_q, valid_out_d;
    logic [NUM_PORTS-1:0]        rcv_rdy_q, rcv_rdy_d;
    logic [15:0]                 drop_cnt_q, drop_cnt_d;

    logic [NUM_PORTS-1:0]        legal, drop, grant;
    logic [DEST_W-1:0]           dest [NUM_PORTS];

    // Address is legal only when every bit above the destination field is clear
    always_comb begin
        logic [ADDR_W-1:0] a;
        for (int i = 0; i < NUM_PORTS; i++) begin
            a        = addr_in[i*ADDR_W +: ADDR_W];
            dest[i]  = a[DEST_W-1:0];
            legal[i] = ((a >> DEST_W) == '0) && (int'(dest[i]) < NUM_PORTS);
            drop[i]  = valid_in[i] && !legal[i];
        end
    end

    always_comb begin
        logic found, push, pop;
        int   gsel, idx;
        mem_d       = mem_q;
        addr_out_d  = addr_out_q;
        data_out_d  = data_out_q;
        valid_out_d = '0;
        rcv_rdy_d   = '0;
        grant       = '0;
        for (int j = 0; j < NUM_PORTS; j++) begin
            wr_d[j]  = wr_q[j];
            rd_d[j]  = rd_q[j];
            cnt_d[j] = cnt_q[j];
            rr_d[j]  = rr_q[j];
            found    = 1'b0;
            gsel     = 0;
            for (int k = 0; k < NUM_PORTS; k++) begin
                idx = (int'(rr_q[j]) + k) % NUM_PORTS;
                if (!found && valid_in[idx] && legal[idx] && int'(dest[idx]) == j) begin
                    found = 1'b1;
                    gsel  = idx;
                end
            end
            // Full blocks a push even when a pop frees a slot on the same edge
            push = found && (cnt_q[j] != CNT_W'(FIFO_DEPTH));
            pop  = data_rd[j] && (cnt_q[j] != '0);
            if (push) begin
                mem_d[j][wr_q[j]] = {addr_in[gsel*ADDR_W +: ADDR_W], data_in[gsel*DATA_W +: DATA_W]};
                wr_d[j]     = wr_q[j] + 1'b1;
                rr_d[j]     = DEST_W'((gsel + 1) % NUM_PORTS);
                grant[gsel] = 1'b1;
            end
            if (pop) begin
                addr_out_d[j*ADDR_W +: ADDR_W] = mem_q[j][rd_q[j]][ENT_W-1 -: ADDR_W];
                data_out_d[j*DATA_W +: DATA_W] = mem_q[j][rd_q[j]][DATA_W-1:0];
                rd_d[j] = rd_q[j] + 1'b1;
            end
            if (push && !pop)
                cnt_d[j] = cnt_q[j] + 1'b1;
            else if (pop && !push)
                cnt_d[j] = cnt_q[j] - 1'b1;
            valid_out_d[j] = pop;
            rcv_rdy_d[j]   = (cnt_d[j] != '0);
        end
    end

    always_comb begin
        logic [16:0] sum;
        sum = {1'b0, drop_cnt_q};
        for (int i = 0; i < NUM_PORTS; i++)
            sum = sum + 17'(drop[i]);
        drop_cnt_d = sum[16] ? 16'hFFFF : sum[15:0];
    end

    assign in_ack = reset ? (grant | drop) : '0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            addr_out_q  <= '0;
            data_out_q  <= '0;
            valid_out_q <= '0;
            rcv_rdy_q   <= '0;
            drop_cnt_q  <= '0;
            for (int j = 0; j < NUM_PORTS; j++) begin
                wr_q[j]  <= '0;
                rd_q[j]  <= '0;
                cnt_q[j] <= '0;
                rr_q[j]  <= '0;
            end
        end else begin
            addr_out_q  <= addr_out_d;
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
            rcv_rdy_q   <= rcv_rdy_d;
            drop_cnt_q  <= drop_cnt_d;
            for (int j = 0; j < NUM_PORTS; j++) begin
                wr_q[j]  <= wr_d[j];
                rd_q[j]  <= rd_d[j];
                cnt_q[j] <= cnt_d[j];
                rr_q[j]  <= rr_d[j];
            end
        end
    end

    // Storage needs no reset: occupancy is tracked by the pointers and counts
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign addr_out  = addr_out_q;
    assign data_out  = data_out_q;
    assign valid_out = valid_out_q;
    assign rcv_rdy   = rcv_rdy_q;
    assign drop_cnt  = drop_cnt_q;
endmodule

// File: tb/tb_switch_nxn_core.sv
// Directed bench for switch_nxn_core (4 ports): expected words are queued per output
// when accepted, and a negedge monitor checks every valid_out pulse against them.
module tb_switch_nxn_core;
    localparam int N = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [N*8-1:0] addr_in, data_in, addr_out, data_out;
    logic [N-1:0]  valid_in, in_ack, data_rd, valid_out, rcv_rdy;
    logic [15:0]   drop_cnt;

    int total = 0;
    int bad   = 0;
    logic [15:0] exp_q [N][$];

    switch_nxn_core #(.NUM_PORTS(N), .ADDR_W(8), .DATA_W(8), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .addr_in(addr_in), .data_in(data_in),
        .valid_in(valid_in), .in_ack(in_ack), .data_rd(data_rd),
        .addr_out(addr_out), .data_out(data_out), .valid_out(valid_out),
        .rcv_rdy(rcv_rdy), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        for (int j = 0; j < N; j++) begin
            if (valid_out[j]) begin
                total++;
                if (exp_q[j].size() == 0) begin
                    bad++;
                    $display("FAIL phantom_out lane%0d got=%h_%h expected none", j,
                             addr_out[j*8 +: 8], data_out[j*8 +: 8]);
                end else begin
                    logic [15:0] e;
                    e = exp_q[j].pop_front();
                    if ({addr_out[j*8 +: 8], data_out[j*8 +: 8]} !== e) begin
                        bad++;
                        $display("FAIL word_out lane%0d got=%h_%h expected=%h", j,
                                 addr_out[j*8 +: 8], data_out[j*8 +: 8], e);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int i, input logic [7:0] a, input logic [7:0] d, input logic v);
        addr_in[i*8 +: 8] = a;
        data_in[i*8 +: 8] = d;
        valid_in[i]       = v;
    endtask

    logic [N-1:0] ack_tab [3] = '{4'b0001, 4'b0010, 4'b1000};

    initial begin
        reset = 1'b0; addr_in = '0; data_in = '0; valid_in = '0; data_rd = '0;
        step();
        valid_in = 4'b0001; data_rd = 4'b1111;
        @(negedge clk);
        chk("rst_in_ack", 32'(in_ack), 32'h0);
        chk("rst_rcv_rdy", 32'(rcv_rdy), 32'h0);
        chk("rst_valid_out", 32'(valid_out), 32'h0);
        chk("rst_drop_cnt", 32'(drop_cnt), 32'h0);
        step();
        valid_in = '0; data_rd = '0; reset = 1'b1;
        step();

        // single word lane0 -> port 2
        set_lane(0, 8'h02, 8'hA5, 1'b1);
        @(negedge clk);
        chk("t1_in_ack", 32'(in_ack), 32'h1);
        if (in_ack[0]) exp_q[2].push_back(16'h02A5);
        step();
        valid_in = '0;
        @(negedge clk);
        chk("t1_rcv_rdy_up", 32'(rcv_rdy[2]), 32'h1);
        step();
        data_rd[2] = 1'b1;
        step();
        data_rd = '0;
        @(negedge clk);
        chk("t1_valid_out", 32'(valid_out[2]), 32'h1);
        chk("t1_rcv_rdy_down", 32'(rcv_rdy[2]), 32'h0);
        step();

        // lanes 0,1,3 contend for port 1
        set_lane(0, 8'h01, 8'h10, 1'b1);
        set_lane(1, 8'h01, 8'h11, 1'b1);
        set_lane(3, 8'h01, 8'h13, 1'b1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("t2_rr_ack%0d", c), 32'(in_ack), 32'(ack_tab[c]));
            for (int i = 0; i < N; i++)
                if (in_ack[i]) exp_q[1].push_back({8'h01, data_in[i*8 +: 8]});
            step();
            valid_in = valid_in & ~ack_tab[c];
        end
        data_rd[1] = 1'b1;
        repeat (3) step();
        data_rd = '0;
        step();

        // lane2 fills port 0, fifth word waits for a pop
        for (int w = 0; w < 5; w++) begin
            set_lane(2, 8'h00, 8'(8'h20 + w), 1'b1);
            @(negedge clk);
            chk($sformatf("t3_ack_w%0d", w), 32'(in_ack[2]), (w < 4) ? 32'h1 : 32'h0);
            if (in_ack[2]) exp_q[0].push_back({8'h00, data_in[23:16]});
            if (w < 4) step();
        end
        step();
        @(negedge clk);
        chk("t3_held_ack", 32'(in_ack[2]), 32'h0);
        chk("t3_full_rdy", 32'(rcv_rdy[0]), 32'h1);
        step();
        data_rd[0] = 1'b1;
        @(negedge clk);
        chk("t3_pop_cycle_ack", 32'(in_ack[2]), 32'h0);
        step();
        data_rd = '0;
        @(negedge clk);
        chk("t3_after_pop_ack", 32'(in_ack[2]), 32'h1);
        if (in_ack[2]) exp_q[0].push_back(16'h0024);
        step();
        valid_in = '0;
        data_rd[0] = 1'b1;
        repeat (4) step();
        data_rd = '0;
        @(negedge clk);
        chk("t3_drained_rdy", 32'(rcv_rdy[0]), 32'h0);
        step();

        // illegal address drops and saturation
        set_lane(1, 8'h10, 8'h77, 1'b1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("t4_drop_ack%0d", c), 32'(in_ack), 32'h2);
            step();
        end
        valid_in = '0;
        @(negedge clk);
        chk("t4_drop_cnt3", 32'(drop_cnt), 32'h3);
        chk("t4_no_rdy", 32'(rcv_rdy), 32'h0);
        for (int i = 0; i < N; i++) set_lane(i, 8'hFF, 8'h00, 1'b1);
        step();
        @(negedge clk);
        chk("t4_drop_cnt7", 32'(drop_cnt), 32'h7);
        repeat (16400) step();
        @(negedge clk);
        chk("t4_sat_ack", 32'(in_ack), 32'hF);
        chk("t4_saturated", 32'(drop_cnt), 32'hFFFF);
        valid_in = '0; addr_in = '0;
        step();

        // reads on an empty FIFO
        data_rd[3] = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            @(negedge clk);
            chk($sformatf("t5_vout%0d", c), 32'(valid_out[3]), 32'h0);
            chk($sformatf("t5_rdy%0d", c), 32'(rcv_rdy[3]), 32'h0);
        end
        data_rd = '0;
        repeat (2) step();

        // reset with a loaded FIFO and a read in flight
        for (int w = 0; w < 3; w++) begin
            set_lane(0, 8'h00, 8'(8'h30 + w), 1'b1);
            @(negedge clk);
            chk($sformatf("t6_ack%0d", w), 32'(in_ack[0]), 32'h1);
            step();
        end
        valid_in = '0;
        @(negedge clk);
        chk("t6_loaded_rdy", 32'(rcv_rdy[0]), 32'h1);
        step();
        reset = 1'b0; data_rd[0] = 1'b1;
        step();
        reset = 1'b1; data_rd[0] = 1'b0;
        @(negedge clk);
        chk("t6_rst_rdy", 32'(rcv_rdy), 32'h0);
        chk("t6_rst_vout", 32'(valid_out), 32'h0);
        chk("t6_rst_drop", 32'(drop_cnt), 32'h0);
        data_rd[0] = 1'b1;
        repeat (2) step();
        data_rd = '0;
        @(negedge clk);
        chk("t6_post_rdy", 32'(rcv_rdy[0]), 32'h0);
        repeat (3) step();

        for (int j = 0; j < N; j++)
            chk($sformatf("leftover_q%0d", j), 32'(exp_q[j].size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/switch_nxn_core.md
Name: switch_nxn_core

Overview:
- Parametrised N-port packet switch; the next generation of the fixed 4-port, byte-lane switch DUT.
- Each input lane carries one address and one data word per cycle and is routed to the output selected by its address.
- Each output has a FIFO and a rcv_rdy/data_rd pull handshake.
- Adds over the previous generation: round-robin arbitration per output, input back-pressure (in_ack), and a saturating counter of dropped illegal addresses.

Parameters:
NUM_PORTS, 4, number of input and output ports (2..16)
ADDR_W, 8, address lane width per port (must be >= clog2(NUM_PORTS))
DATA_W, 8, data lane width per port
FIFO_DEPTH, 4, entries per output FIFO (power of 2, >= 2)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-low reset
addr_in  input  NUM_PORTS*ADDR_W  per-input destination address, lane i = bits [i*ADDR_W +: ADDR_W]
data_in  input  NUM_PORTS*DATA_W  per-input data word, lane i
valid_in  input  NUM_PORTS  lane i carries a word this cycle
in_ack  output  NUM_PORTS  combinational: lane i word accepted this cycle
data_rd  input  NUM_PORTS  receiver j requests one word
addr_out  output  NUM_PORTS*ADDR_W  address of the popped word, lane j
data_out  output  NUM_PORTS*DATA_W  popped data word, lane j
valid_out  output  NUM_PORTS  lane j addr_out/data_out valid, one-cycle pulse
rcv_rdy  output  NUM_PORTS  output FIFO j not empty (registered)
drop_cnt  output  16  count of dropped illegal-address words, saturating

Behaviour:
- Reset (reset==0 at a clk edge):
  - All FIFOs emptied; all round-robin pointers = 0.
  - addr_out, data_out, valid_out, rcv_rdy, drop_cnt = 0.
  - in_ack forced 0 while reset is low.
- Decode, lane i:
  - dest = addr_in lane low clog2(NUM_PORTS) bits.
  - Address is illegal if any higher bit is set, or if dest >= NUM_PORTS.
- Illegal word with valid_in[i]=1:
  - in_ack[i]=1 (consumed) and the word is discarded.
  - drop_cnt increments by the number of such lanes this cycle, saturating at 16'hFFFF.
- Arbitration, per output j:
  - Requesters are the lanes with valid_in=1, a legal address and dest==j.
  - If FIFO j is not full, grant exactly one requester, in round-robin order starting at rr_ptr[j].
  - On a grant: write {addr, data} to FIFO j and set rr_ptr[j] = grantee+1 (mod NUM_PORTS).
  - If FIFO j is full: no grant and the pointer does not change.
- Back-pressure:
  - in_ack[i]=1 only for a granted or dropped lane.
  - A source whose in_ack is 0 must hold addr/data/valid stable; the core has no input buffering.
- Full rule: FIFO full = count==FIFO_DEPTH. A push is blocked even if a pop occurs on the same cycle.
- Empty FIFO: simultaneous push and pop is not possible, because a pop requires rcv_rdy=1 at the preceding edge.
- Read, per output j:
  - data_rd[j]=1 sampled at edge t while FIFO j is non-empty pops the head.
  - After edge t: addr_out/data_out lane j = head entry and valid_out[j]=1 for exactly one cycle.
  - At the next edge without a read, valid_out[j] returns to 0; addr_out/data_out hold their last value.
  - data_rd[j] while empty: ignored; no valid_out and no underflow.
- Back-to-back reads: data_rd held high gives one word per cycle until empty.
- Same-cycle push and pop on a non-empty, non-full FIFO: count unchanged; the read returns the prior head.
- rcv_rdy[j]: registered, = (count_next != 0).
  - A push at edge t raises rcv_rdy after t.
  - A pop of the last entry lowers it after the same edge.
- Pointers wrap modulo FIFO_DEPTH; count width is clog2(FIFO_DEPTH)+1.
- Reset mid-operation: FIFO contents are lost and valid_out drops in the same cycle as the reset edge; no partial word is emitted.

Test Plan:
- Reset, then lane 0 drives addr=2, data=8'hA5, valid for 1 cycle -> in_ack[0]=1; rcv_rdy[2]=1 after that edge; data_rd[2] pulse -> next cycle valid_out[2]=1, data_out lane2=8'hA5, addr_out lane2=8'h02; rcv_rdy[2]=0.
- Lanes 0, 1, 3 all target port 1 simultaneously and hold valid -> grants in order 0, 1, 3 on consecutive cycles; 3 words read back in that order.
- Lane 2 pushes 5 words to port 0 with no reads (FIFO_DEPTH=4) -> in_ack[2]=1 for the first 4; 5th held with in_ack=0 until one data_rd[0], then accepted on the cycle after the pop edge.
- Lane 1 sends addr=8'h10 valid for 3 cycles -> in_ack[1]=1 each cycle, drop_cnt=3, no rcv_rdy change; preload drop_cnt near 16'hFFFF via repeated drops -> holds at 16'hFFFF.
- data_rd[3]=1 with FIFO 3 empty for 4 cycles -> valid_out[3] stays 0, rcv_rdy[3] stays 0, no later phantom word.
- FIFO 0 holding 3 words, reset low for 1 cycle -> rcv_rdy=0, valid_out=0, drop_cnt=0; a subsequent data_rd[0] yields nothing.
